fetch_unit: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the decode/control stage.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and one-word-at-a-time instruction fetch FSM (FETCH -> WAIT -> ISSUE).
// Optional FETCH_HALT_EN adds halt/halted to freeze fetching while in FETCH.
module fetch_unit #(
   parameter int                    PC_WIDTH = 26,
   parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
   parameter int                    MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef FETCH_HALT_EN
   input  logic                halt,
   output logic                halted,
`endif
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                imem_valid,
   output logic [31:0]         instruction,
   output logic                instr_valid,
   input  logic                stall,
   input  logic                load_pc,
   input  logic [25:0]         load_pc_val,
   output logic [PC_WIDTH-1:0] pc,
   output logic                fetch_err
);
   typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;
   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         instr_q, instr_d;
   logic                valid_q, valid_d, err_q, err_d, hold;
   logic [7:0]          cnt_q, cnt_d;
`ifdef FETCH_HALT_EN
   assign hold   = halt;
   assign halted = rst_n && state_q == FETCH && halt;
`else
   assign hold = 1'b0;
`endif
   // Request is a pure decode of FETCH so the strobe lasts exactly one cycle.
   assign imem_req    = rst_n && state_q == FETCH && !hold;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   always_comb begin
      state_d = FETCH;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         FETCH: begin
            cnt_d   = '0;
            state_d = hold ? FETCH : WAIT;
         end
         WAIT: begin
            if (imem_valid) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ISSUE;
            end else if (cnt_q + 8'd1 == 8'(MAX_WAIT)) begin
               err_d   = 1'b1;
               instr_d = '0;
               valid_d = 1'b1;
               state_d = ISSUE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = WAIT;
            end
         end
         ISSUE: begin
            if (stall) begin
               state_d = ISSUE;
            end else begin
               instr_d = '0;
               valid_d = 1'b0;
               pc_d    = load_pc ? PC_WIDTH'(load_pc_val) : pc_q + 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        imem_req, imem_valid, instr_valid, stall, load_pc, fetch_err;
   logic [25:0] imem_addr, pc, load_pc_val, exp_pc;
   logic [31:0] imem_rdata, instruction;
   logic        exp_err;
   int          total = 0, bad = 0;
`ifdef FETCH_HALT_EN
   logic        halt = 1'b0, halted;
`endif
   always #5 clk = ~clk;
   fetch_unit #(.PC_WIDTH(26), .RESET_PC(26'd0), .MAX_WAIT(15)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef FETCH_HALT_EN
      .halt(halt), .halted(halted),
`endif
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .instruction(instruction), .instr_valid(instr_valid),
      .stall(stall), .load_pc(load_pc), .load_pc_val(load_pc_val), .pc(pc),
      .fetch_err(fetch_err)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   // One instruction: lat = WAIT cycle carrying imem_valid (>15 means never), stalls = ISSUE hold cycles.
   task automatic fetch_one(input int lat, input logic [31:0] data, input int stalls,
                            input logic ld, input logic [25:0] tgt);
      int          nw;
      logic [31:0] exp_i;
      nw    = lat > 15 ? 15 : lat;
      exp_i = lat > 15 ? 32'h0 : data;
      @(negedge clk);
      chk("req_fetch", 32'(imem_req), 32'd1);
      chk("addr", 32'(imem_addr), 32'(exp_pc));
      chk("pc", 32'(pc), 32'(exp_pc));
      chk("valid_fetch", 32'(instr_valid), 32'd0);
      @(posedge clk); #1;
      for (int k = 1; k <= nw; k++) begin
         imem_valid  = (k == lat);
         imem_rdata  = (k == lat) ? data : $urandom;
         stall       = 1'($urandom);
         load_pc     = 1'($urandom);
         load_pc_val = 26'($urandom);
         @(negedge clk);
         chk("req_wait", 32'(imem_req), 32'd0);
         chk("valid_wait", 32'(instr_valid), 32'd0);
         @(posedge clk); #1;
      end
      if (lat > 15) exp_err = 1'b1;
      for (int s = 0; s <= stalls; s++) begin
         stall       = (s < stalls);
         load_pc     = (s < stalls) ? 1'b1 : ld;
         load_pc_val = (s < stalls) ? 26'($urandom) : tgt;
         imem_valid  = 1'($urandom);
         imem_rdata  = $urandom;
         @(negedge clk);
         chk("valid_issue", 32'(instr_valid), 32'd1);
         chk("instr", instruction, exp_i);
         chk("req_issue", 32'(imem_req), 32'd0);
         chk("err", 32'(fetch_err), 32'(exp_err));
         @(posedge clk); #1;
      end
      exp_pc     = ld ? tgt : exp_pc + 26'd1;
      stall      = 1'b0;
      load_pc    = 1'b0;
      imem_valid = 1'b0;
   endtask
   initial begin
      imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0; load_pc = 1'b0; load_pc_val = '0;
      exp_pc = '0; exp_err = 1'b0;
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) fetch_one(1, 32'h04221000, 0, 1'b0, '0);
      fetch_one(2, $urandom, 2, 1'b1, 26'h40);
      fetch_one(1, $urandom, 5, 1'b0, '0);
      for (int i = 0; i < 20; i++)
         fetch_one(int'($urandom_range(1, 6)), $urandom, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 26'($urandom));
      fetch_one(15, 32'hCAFE0015, 0, 1'b0, '0);
      fetch_one(16, 32'hDEADBEEF, 1, 1'b0, '0);
      fetch_one(1, $urandom, 0, 1'b0, '0);
      fetch_one(1, $urandom, 0, 1'b1, 26'h3FFFFFF);
      fetch_one(1, $urandom, 0, 1'b0, '0);
      @(negedge clk);
      chk("wrap_addr", 32'(imem_addr), 32'd0);
      @(posedge clk); #1;
      imem_valid = 1'b1; imem_rdata = 32'h12345678;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_req", 32'(imem_req), 32'd0);
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_instr", instruction, 32'd0);
      chk("midrst_pc", 32'(pc), 32'd0);
      chk("midrst_err", 32'(fetch_err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; imem_valid = 1'b0; exp_pc = '0; exp_err = 1'b0;
      fetch_one(1, $urandom, 1, 1'b0, '0);
`ifdef FETCH_HALT_EN
      halt = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("halt_req", 32'(imem_req), 32'd0);
         chk("halted", 32'(halted), 32'd1);
         chk("halt_pc", 32'(pc), 32'(exp_pc));
         @(posedge clk); #1;
      end
      halt = 1'b0;
      fetch_one(1, $urandom, 0, 1'b0, '0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
